// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the decode stage.
//   - RV base opcode encodings used by the decoder
//   - ECALL instruction encoding
//   - immediate-format enum produced by imm_gen
//   - helper telling whether an OP-IMM funct3 selects a shift
package decode_pkg;

    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] SYSTEM    = 7'b1110011;

    localparam logic [31:0] ECALL_ENC = 32'h00000073;

    typedef enum logic [2:0] {
        IMM_I  = 3'd0,
        IMM_S  = 3'd1,
        IMM_B  = 3'd2,
        IMM_U  = 3'd3,
        IMM_J  = 3'd4,
        IMM_SH = 3'd5
    } imm_fmt_e;

    // SLLI/SRLI/SRAI (and their -W forms) use funct3 001 and 101
    function automatic logic is_shift_f3(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/decode_stage_fwd_imm_gen.sv
// imm_gen: combinational immediate generator.
//   ir_i  [31:0]     instruction word
//   imm_o [XLEN-1:0] immediate; I/S/B/U/J sign-extended, shift amounts zero-extended
//   fmt_o            immediate format selected for this opcode
// Shift amount is 6 bits for OP-IMM at XLEN=64, otherwise 5 bits (OP-IMM-32, XLEN=32).
module imm_gen
    import decode_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     ir_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_e        fmt_o
);

    logic [6:0]  opc_s;
    logic [31:0] raw32_s;
    logic [5:0]  shamt_s;

    assign opc_s = ir_i[6:0];

    // format selection from the opcode
    always_comb begin
        fmt_o = IMM_I;
        case (opc_s)
            STORE:           fmt_o = IMM_S;
            BRANCH:          fmt_o = IMM_B;
            LUI, AUIPC:      fmt_o = IMM_U;
            JAL:             fmt_o = IMM_J;
            OP_IMM, OP_IMM_32: begin
                if (is_shift_f3(ir_i[14:12])) begin
                    fmt_o = IMM_SH;
                end else begin
                    fmt_o = IMM_I;
                end
            end
            default:         fmt_o = IMM_I;
        endcase
    end

    // assemble the 32-bit immediate and the shift amount, then extend to XLEN
    always_comb begin
        raw32_s = {{20{ir_i[31]}}, ir_i[31:20]};
        case (fmt_o)
            IMM_I:   raw32_s = {{20{ir_i[31]}}, ir_i[31:20]};
            IMM_S:   raw32_s = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
            IMM_B:   raw32_s = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
            IMM_U:   raw32_s = {ir_i[31:12], 12'h000};
            IMM_J:   raw32_s = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
            default: raw32_s = {{20{ir_i[31]}}, ir_i[31:20]};
        endcase

        // only RV64 OP-IMM owns the sixth shamt bit; elsewhere bit 25 is funct7
        if ((XLEN == 64) && (opc_s == OP_IMM)) begin
            shamt_s = ir_i[25:20];
        end else begin
            shamt_s = {1'b0, ir_i[24:20]};
        end

        if (fmt_o == IMM_SH) begin
            imm_o = XLEN'(shamt_s);
        end else begin
            imm_o = XLEN'($signed(raw32_s));
        end
    end

endmodule

// File: rtl/decode_stage_fwd.sv
// decode_stage_fwd: decode stage between the DE and EXE latches.
//   Inputs : CLK, reset (sync, active-low), DE latch (DE_V/DE_NPC/DE_IR),
//            register-file read data (RF_RS1/RF_RS2), EXE/MEM/WB forwarding
//            info, MEM_STALL (hold EXE latch) and FLUSH (kill DE instruction).
//   Outputs: SR1_ID/SR2_ID read indices, DE_STALL load-use interlock,
//            v_de_br_stall control-flow indicator, the registered EXE latch
//            (EXE_*), and STALL_CNT.
// Optional feature: define DE_STALL_CNT_EN to build a saturating counter of
// interlock bubbles on STALL_CNT; otherwise STALL_CNT is constant 0.
module decode_stage_fwd
    import decode_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             DE_V,
    input  logic [XLEN-1:0]  DE_NPC,
    input  logic [31:0]      DE_IR,
    output logic [4:0]       SR1_ID,
    output logic [4:0]       SR2_ID,
    input  logic [XLEN-1:0]  RF_RS1,
    input  logic [XLEN-1:0]  RF_RS2,
    input  logic             EXE_FWD_V,
    input  logic             EXE_FWD_LD_REG,
    input  logic             EXE_FWD_IS_LOAD,
    input  logic [4:0]       EXE_FWD_DRID,
    input  logic [XLEN-1:0]  EXE_FWD_DATA,
    input  logic             MEM_FWD_V,
    input  logic             MEM_FWD_LD_REG,
    input  logic             MEM_FWD_IS_LOAD,
    input  logic [4:0]       MEM_FWD_DRID,
    input  logic [XLEN-1:0]  MEM_ALU_RESULT,
    input  logic [XLEN-1:0]  MEM_MEM_RESULT,
    input  logic             WB_FWD_V,
    input  logic             WB_FWD_LD_REG,
    input  logic [4:0]       WB_FWD_DRID,
    input  logic [XLEN-1:0]  WB_FWD_DATA,
    input  logic             MEM_STALL,
    input  logic             FLUSH,
    output logic             DE_STALL,
    output logic             v_de_br_stall,
    output logic             EXE_V,
    output logic             EXE_ECALL,
    output logic             EXE_ILLEGAL,
    output logic [XLEN-1:0]  EXE_NPC,
    output logic [XLEN-1:0]  EXE_ALU_ONE,
    output logic [XLEN-1:0]  EXE_ALU_TWO,
    output logic [XLEN-1:0]  EXE_STORE_DATA,
    output logic [XLEN-1:0]  EXE_IMM,
    output logic [31:0]      EXE_IR,
    output logic [4:0]       EXE_DRID,
    output logic [CNT_W-1:0] STALL_CNT
);

    logic [6:0]      opc_s;
    logic [4:0]      rs1_s, rs2_s, rd_s;
    logic [XLEN-1:0] imm_s;
    imm_fmt_e        imm_fmt_s;
    logic            rs1_used_s, rs2_used_s, known_s;
    logic [XLEN-1:0] rs1_val_s, rs2_val_s;
    logic [XLEN-1:0] alu_one_s, alu_two_s;
    logic [4:0]      drid_s;
    logic            illegal_s, ld_hit_s;

    logic            exe_v_q, exe_v_d;
    logic            exe_ecall_q, exe_ecall_d;
    logic            exe_ill_q, exe_ill_d;
    logic [XLEN-1:0] exe_npc_q, exe_npc_d;
    logic [XLEN-1:0] exe_a1_q, exe_a1_d;
    logic [XLEN-1:0] exe_a2_q, exe_a2_d;
    logic [XLEN-1:0] exe_st_q, exe_st_d;
    logic [XLEN-1:0] exe_imm_q, exe_imm_d;
    logic [31:0]     exe_ir_q, exe_ir_d;
    logic [4:0]      exe_drid_q, exe_drid_d;

    assign opc_s  = DE_IR[6:0];
    assign rd_s   = DE_IR[11:7];
    assign rs1_s  = DE_IR[19:15];
    assign rs2_s  = DE_IR[24:20];
    assign SR1_ID = rs1_s;
    assign SR2_ID = rs2_s;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .ir_i  (DE_IR),
        .imm_o (imm_s),
        .fmt_o (imm_fmt_s)
    );

    // Forwarded source value: x0 is hard zero; a load in EXE has no data yet,
    // so it is skipped here and covered by the interlock instead.
    function automatic logic [XLEN-1:0] fwd_f(input logic [4:0] src, input logic [XLEN-1:0] rf);
        if (src == 5'd0) begin
            fwd_f = {XLEN{1'b0}};
        end else if (EXE_FWD_V && EXE_FWD_LD_REG && !EXE_FWD_IS_LOAD && (EXE_FWD_DRID == src)) begin
            fwd_f = EXE_FWD_DATA;
        end else if (MEM_FWD_V && MEM_FWD_LD_REG && (MEM_FWD_DRID == src)) begin
            fwd_f = MEM_FWD_IS_LOAD ? MEM_MEM_RESULT : MEM_ALU_RESULT;
        end else if (WB_FWD_V && WB_FWD_LD_REG && (WB_FWD_DRID == src)) begin
            fwd_f = WB_FWD_DATA;
        end else begin
            fwd_f = rf;
        end
    endfunction

    assign rs1_val_s = fwd_f(rs1_s, RF_RS1);
    assign rs2_val_s = fwd_f(rs2_s, RF_RS2);

    // opcode classification: which sources are read and whether the opcode exists
    always_comb begin
        rs1_used_s = 1'b0;
        rs2_used_s = 1'b0;
        known_s    = 1'b1;
        case (opc_s)
            OP, OP_32, STORE, BRANCH: begin
                rs1_used_s = 1'b1;
                rs2_used_s = 1'b1;
            end
            OP_IMM, OP_IMM_32, LOAD, JALR: begin
                rs1_used_s = 1'b1;
            end
            JAL, LUI, AUIPC, SYSTEM: begin
                rs1_used_s = 1'b0;
            end
            default: begin
                known_s = 1'b0;
            end
        endcase
    end

    assign ld_hit_s = EXE_FWD_V && EXE_FWD_IS_LOAD && (EXE_FWD_DRID != 5'd0) &&
                      ((rs1_used_s && (EXE_FWD_DRID == rs1_s)) ||
                       (rs2_used_s && (EXE_FWD_DRID == rs2_s)));

    // a flushed instruction is dead, so it never requests an interlock
    assign DE_STALL      = DE_V && !FLUSH && ld_hit_s;
    assign v_de_br_stall = DE_V && ((opc_s == BRANCH) || (opc_s == JAL) || (opc_s == JALR));

    // ALU operand selection, destination and illegal-instruction decode
    always_comb begin
        alu_one_s = rs1_val_s;
        case (opc_s)
            AUIPC, JAL: alu_one_s = DE_NPC - XLEN'(3'd4);
            LUI:        alu_one_s = {XLEN{1'b0}};
            default:    alu_one_s = rs1_val_s;
        endcase

        alu_two_s = imm_s;
        case (opc_s)
            OP, OP_32, BRANCH: alu_two_s = rs2_val_s;
            default:           alu_two_s = imm_s;
        endcase

        drid_s = rd_s;
        case (opc_s)
            STORE, BRANCH: drid_s = 5'd0;
            default:       drid_s = rd_s;
        endcase

        // on RV32 the W-forms do not exist and shamt[5] must be zero
        illegal_s = !known_s ||
                    ((XLEN == 32) && ((opc_s == OP_32) || (opc_s == OP_IMM_32))) ||
                    ((XLEN == 32) && (opc_s == OP_IMM) && (imm_fmt_s == IMM_SH) && DE_IR[25]);
    end

    // EXE latch next state: MEM_STALL freezes everything, FLUSH/interlock insert a bubble
    always_comb begin
        exe_v_d     = exe_v_q;
        exe_ecall_d = exe_ecall_q;
        exe_ill_d   = exe_ill_q;
        exe_npc_d   = exe_npc_q;
        exe_a1_d    = exe_a1_q;
        exe_a2_d    = exe_a2_q;
        exe_st_d    = exe_st_q;
        exe_imm_d   = exe_imm_q;
        exe_ir_d    = exe_ir_q;
        exe_drid_d  = exe_drid_q;
        if (MEM_STALL) begin
            exe_v_d = exe_v_q;
        end else begin
            exe_v_d     = DE_V && !FLUSH && !DE_STALL;
            exe_ecall_d = (DE_IR == ECALL_ENC);
            exe_ill_d   = illegal_s;
            exe_npc_d   = DE_NPC;
            exe_a1_d    = alu_one_s;
            exe_a2_d    = alu_two_s;
            exe_st_d    = rs2_val_s;
            exe_imm_d   = imm_s;
            exe_ir_d    = DE_IR;
            exe_drid_d  = drid_s;
        end
    end

    // EXE latch registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!reset) begin
            exe_v_q     <= 1'b0;
            exe_ecall_q <= 1'b0;
            exe_ill_q   <= 1'b0;
            exe_npc_q   <= {XLEN{1'b0}};
            exe_a1_q    <= {XLEN{1'b0}};
            exe_a2_q    <= {XLEN{1'b0}};
            exe_st_q    <= {XLEN{1'b0}};
            exe_imm_q   <= {XLEN{1'b0}};
            exe_ir_q    <= 32'h0000_0000;
            exe_drid_q  <= 5'd0;
        end else begin
            exe_v_q     <= exe_v_d;
            exe_ecall_q <= exe_ecall_d;
            exe_ill_q   <= exe_ill_d;
            exe_npc_q   <= exe_npc_d;
            exe_a1_q    <= exe_a1_d;
            exe_a2_q    <= exe_a2_d;
            exe_st_q    <= exe_st_d;
            exe_imm_q   <= exe_imm_d;
            exe_ir_q    <= exe_ir_d;
            exe_drid_q  <= exe_drid_d;
        end
    end

    assign EXE_V          = exe_v_q;
    assign EXE_ECALL      = exe_ecall_q;
    assign EXE_ILLEGAL    = exe_ill_q;
    assign EXE_NPC        = exe_npc_q;
    assign EXE_ALU_ONE    = exe_a1_q;
    assign EXE_ALU_TWO    = exe_a2_q;
    assign EXE_STORE_DATA = exe_st_q;
    assign EXE_IMM        = exe_imm_q;
    assign EXE_IR         = exe_ir_q;
    assign EXE_DRID       = exe_drid_q;

`ifdef DE_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // saturating count of bubbles actually inserted by the interlock
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (DE_STALL && !MEM_STALL && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1'b1);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // stall counter register
    always_ff @(posedge CLK) begin
        if (!reset) begin
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign STALL_CNT = stall_cnt_q;
`else
    assign STALL_CNT = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_decode_stage_fwd.sv
// Scoreboard bench for decode_stage_fwd: the driver applies directed vectors on
// the falling edge and queues the hand-computed expectation; the monitor pops one
// entry after each rising edge and compares. A second instance at XLEN=32 shares
// the DE inputs to cover the RV32-only decode rules.
module tb_decode_stage_fwd;

    logic        CLK;
    logic        reset;
    logic        DE_V;
    logic [63:0] DE_NPC;
    logic [31:0] DE_IR;
    logic [4:0]  SR1_ID, SR2_ID;
    logic [63:0] RF_RS1, RF_RS2;
    logic        EXE_FWD_V, EXE_FWD_LD_REG, EXE_FWD_IS_LOAD;
    logic [4:0]  EXE_FWD_DRID;
    logic [63:0] EXE_FWD_DATA;
    logic        MEM_FWD_V, MEM_FWD_LD_REG, MEM_FWD_IS_LOAD;
    logic [4:0]  MEM_FWD_DRID;
    logic [63:0] MEM_ALU_RESULT, MEM_MEM_RESULT;
    logic        WB_FWD_V, WB_FWD_LD_REG;
    logic [4:0]  WB_FWD_DRID;
    logic [63:0] WB_FWD_DATA;
    logic        MEM_STALL, FLUSH;
    logic        DE_STALL, v_de_br_stall;
    logic        EXE_V, EXE_ECALL, EXE_ILLEGAL;
    logic [63:0] EXE_NPC, EXE_ALU_ONE, EXE_ALU_TWO, EXE_STORE_DATA, EXE_IMM;
    logic [31:0] EXE_IR;
    logic [4:0]  EXE_DRID;
    logic [15:0] STALL_CNT;

    logic [4:0]  s32_1, s32_2, d32_drid;
    logic        d32_stall, d32_br, d32_v, d32_ecall, d32_ill;
    logic [31:0] d32_npc, d32_a1, d32_a2, d32_st, d32_imm, d32_ir;
    logic [15:0] d32_cnt;

`ifdef DE_STALL_CNT_EN
    localparam int EXP_CNT = 4;
`else
    localparam int EXP_CNT = 0;
`endif

    decode_stage_fwd #(.XLEN(64), .CNT_W(16)) dut (
        .CLK(CLK), .reset(reset), .DE_V(DE_V), .DE_NPC(DE_NPC), .DE_IR(DE_IR),
        .SR1_ID(SR1_ID), .SR2_ID(SR2_ID), .RF_RS1(RF_RS1), .RF_RS2(RF_RS2),
        .EXE_FWD_V(EXE_FWD_V), .EXE_FWD_LD_REG(EXE_FWD_LD_REG), .EXE_FWD_IS_LOAD(EXE_FWD_IS_LOAD),
        .EXE_FWD_DRID(EXE_FWD_DRID), .EXE_FWD_DATA(EXE_FWD_DATA),
        .MEM_FWD_V(MEM_FWD_V), .MEM_FWD_LD_REG(MEM_FWD_LD_REG), .MEM_FWD_IS_LOAD(MEM_FWD_IS_LOAD),
        .MEM_FWD_DRID(MEM_FWD_DRID), .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_MEM_RESULT(MEM_MEM_RESULT),
        .WB_FWD_V(WB_FWD_V), .WB_FWD_LD_REG(WB_FWD_LD_REG), .WB_FWD_DRID(WB_FWD_DRID), .WB_FWD_DATA(WB_FWD_DATA),
        .MEM_STALL(MEM_STALL), .FLUSH(FLUSH), .DE_STALL(DE_STALL), .v_de_br_stall(v_de_br_stall),
        .EXE_V(EXE_V), .EXE_ECALL(EXE_ECALL), .EXE_ILLEGAL(EXE_ILLEGAL), .EXE_NPC(EXE_NPC),
        .EXE_ALU_ONE(EXE_ALU_ONE), .EXE_ALU_TWO(EXE_ALU_TWO), .EXE_STORE_DATA(EXE_STORE_DATA),
        .EXE_IMM(EXE_IMM), .EXE_IR(EXE_IR), .EXE_DRID(EXE_DRID), .STALL_CNT(STALL_CNT)
    );

    decode_stage_fwd #(.XLEN(32), .CNT_W(16)) dut32 (
        .CLK(CLK), .reset(reset), .DE_V(DE_V), .DE_NPC(DE_NPC[31:0]), .DE_IR(DE_IR),
        .SR1_ID(s32_1), .SR2_ID(s32_2), .RF_RS1(32'h0), .RF_RS2(32'h0),
        .EXE_FWD_V(1'b0), .EXE_FWD_LD_REG(1'b0), .EXE_FWD_IS_LOAD(1'b0),
        .EXE_FWD_DRID(5'd0), .EXE_FWD_DATA(32'h0),
        .MEM_FWD_V(1'b0), .MEM_FWD_LD_REG(1'b0), .MEM_FWD_IS_LOAD(1'b0),
        .MEM_FWD_DRID(5'd0), .MEM_ALU_RESULT(32'h0), .MEM_MEM_RESULT(32'h0),
        .WB_FWD_V(1'b0), .WB_FWD_LD_REG(1'b0), .WB_FWD_DRID(5'd0), .WB_FWD_DATA(32'h0),
        .MEM_STALL(MEM_STALL), .FLUSH(FLUSH), .DE_STALL(d32_stall), .v_de_br_stall(d32_br),
        .EXE_V(d32_v), .EXE_ECALL(d32_ecall), .EXE_ILLEGAL(d32_ill), .EXE_NPC(d32_npc),
        .EXE_ALU_ONE(d32_a1), .EXE_ALU_TWO(d32_a2), .EXE_STORE_DATA(d32_st),
        .EXE_IMM(d32_imm), .EXE_IR(d32_ir), .EXE_DRID(d32_drid), .STALL_CNT(d32_cnt)
    );

    typedef struct {
        int          id;
        bit          c_v, c_ill, c_ecall, c_stall, c_br, c_a1, c_a2, c_st, c_imm;
        bit          c_drid, c_cnt, c_ir, c_npc, c_ill32, c_a2_32;
        logic        v, ill, ecall, stall, br, ill32;
        logic [63:0] a1, a2, st, imm, npc;
        logic [31:0] ir, a2_32;
        logic [4:0]  drid;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_pass  = 0;
    int   n_total = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input int id, input string nm, input logic [63:0] act, input logic [63:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL step %0d %s: got %h want %h", id, nm, act, want);
    endtask

    function automatic exp_t blank(input int id);
        exp_t b;
        b = '{default: 0};
        b.id = id;
        return b;
    endfunction

    task automatic go();
        exp_q.push_back(e);
    endtask

    task automatic clr();
        EXE_FWD_V = 1'b0; EXE_FWD_LD_REG = 1'b0; EXE_FWD_IS_LOAD = 1'b0; EXE_FWD_DRID = 5'd0; EXE_FWD_DATA = 64'h0;
        MEM_FWD_V = 1'b0; MEM_FWD_LD_REG = 1'b0; MEM_FWD_IS_LOAD = 1'b0; MEM_FWD_DRID = 5'd0;
        MEM_ALU_RESULT = 64'h0; MEM_MEM_RESULT = 64'h0;
        WB_FWD_V = 1'b0; WB_FWD_LD_REG = 1'b0; WB_FWD_DRID = 5'd0; WB_FWD_DATA = 64'h0;
        MEM_STALL = 1'b0; FLUSH = 1'b0;
    endtask

    task automatic load_x5_in_exe();
        EXE_FWD_V = 1'b1; EXE_FWD_LD_REG = 1'b1; EXE_FWD_IS_LOAD = 1'b1;
        EXE_FWD_DRID = 5'd5; EXE_FWD_DATA = 64'hBAD;
    endtask

    // monitor: one expectation per rising edge, sampled 1 time unit later
    initial begin
        exp_t m;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() != 0) begin
                m = exp_q.pop_front();
                if (m.c_v)     chk(m.id, "exe_v",       64'(EXE_V),       64'(m.v));
                if (m.c_ill)   chk(m.id, "exe_illegal", 64'(EXE_ILLEGAL), 64'(m.ill));
                if (m.c_ecall) chk(m.id, "exe_ecall",   64'(EXE_ECALL),   64'(m.ecall));
                if (m.c_stall) chk(m.id, "de_stall",    64'(DE_STALL),    64'(m.stall));
                if (m.c_br)    chk(m.id, "br_stall",    64'(v_de_br_stall), 64'(m.br));
                if (m.c_a1)    chk(m.id, "alu_one",     EXE_ALU_ONE,      m.a1);
                if (m.c_a2)    chk(m.id, "alu_two",     EXE_ALU_TWO,      m.a2);
                if (m.c_st)    chk(m.id, "store_data",  EXE_STORE_DATA,   m.st);
                if (m.c_imm)   chk(m.id, "exe_imm",     EXE_IMM,          m.imm);
                if (m.c_drid)  chk(m.id, "exe_drid",    64'(EXE_DRID),    64'(m.drid));
                if (m.c_cnt)   chk(m.id, "stall_cnt",   64'(STALL_CNT),   64'(m.cnt));
                if (m.c_ir)    chk(m.id, "exe_ir",      64'(EXE_IR),      64'(m.ir));
                if (m.c_npc)   chk(m.id, "exe_npc",     EXE_NPC,          m.npc);
                if (m.c_ill32) chk(m.id, "rv32_illegal", 64'(d32_ill),    64'(m.ill32));
                if (m.c_a2_32) chk(m.id, "rv32_alu_two", 64'(d32_a2),     64'(m.a2_32));
            end
        end
    end

    // hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: %0d/%0d checks so far", n_pass, n_total);
        $fatal(1, "timeout");
    end

    // driver
    initial begin
        clr();
        reset = 1'b0; DE_V = 1'b1; DE_IR = 32'hFFF00093; DE_NPC = 64'h0;
        RF_RS1 = 64'hDEAD; RF_RS2 = 64'hBEEF;

        // 1: reset clears the EXE latch even with a valid DE instruction
        @(negedge CLK);
        e = blank(1); e.c_v = 1; e.v = 1'b0; e.c_drid = 1; e.drid = 5'd0; e.c_a1 = 1; e.a1 = 64'h0;
        e.c_a2 = 1; e.a2 = 64'h0; e.c_ir = 1; e.ir = 32'h0; e.c_ill = 1; e.ill = 1'b0;
        e.c_cnt = 1; e.cnt = 16'd0; go();

        // 2: ADDI x1,x0,-1 ; rs1=x0 reads 0 despite RF data
        @(negedge CLK); reset = 1'b1;
        e = blank(2); e.c_v = 1; e.v = 1'b1; e.c_a2 = 1; e.a2 = 64'hFFFF_FFFF_FFFF_FFFF; e.c_drid = 1; e.drid = 5'd1;
        e.c_a1 = 1; e.a1 = 64'h0; e.c_ir = 1; e.ir = 32'hFFF00093; e.c_ill = 1; e.ill = 1'b0;
        e.c_ill32 = 1; e.ill32 = 1'b0; e.c_a2_32 = 1; e.a2_32 = 32'hFFFF_FFFF; go();

        // 3: load to x5 in EXE, ADD x6,x5,x7 in DE -> interlock bubble
        @(negedge CLK); clr(); load_x5_in_exe(); DE_IR = 32'h00728333;
        e = blank(3); e.c_stall = 1; e.stall = 1'b1; e.c_v = 1; e.v = 1'b0; go();

        // 4: load now in MEM -> rs1 takes MEM_MEM_RESULT, rs2 from RF
        @(negedge CLK); clr();
        MEM_FWD_V = 1'b1; MEM_FWD_LD_REG = 1'b1; MEM_FWD_IS_LOAD = 1'b1; MEM_FWD_DRID = 5'd5;
        MEM_MEM_RESULT = 64'h1234; MEM_ALU_RESULT = 64'h9999; RF_RS1 = 64'h5555; RF_RS2 = 64'h77;
        e = blank(4); e.c_stall = 1; e.stall = 1'b0; e.c_v = 1; e.v = 1'b1; e.c_a1 = 1; e.a1 = 64'h1234;
        e.c_a2 = 1; e.a2 = 64'h77; e.c_st = 1; e.st = 64'h77; e.c_drid = 1; e.drid = 5'd6; go();

        // 5: EXE/MEM/WB all write x3, ADD x4,x3,x3 -> EXE wins
        @(negedge CLK); clr(); DE_IR = 32'h00318233;
        EXE_FWD_V = 1'b1; EXE_FWD_LD_REG = 1'b1; EXE_FWD_DRID = 5'd3; EXE_FWD_DATA = 64'hA;
        MEM_FWD_V = 1'b1; MEM_FWD_LD_REG = 1'b1; MEM_FWD_DRID = 5'd3; MEM_ALU_RESULT = 64'hB; MEM_MEM_RESULT = 64'hEE;
        WB_FWD_V = 1'b1; WB_FWD_LD_REG = 1'b1; WB_FWD_DRID = 5'd3; WB_FWD_DATA = 64'hC;
        e = blank(5); e.c_a1 = 1; e.a1 = 64'hA; e.c_a2 = 1; e.a2 = 64'hA; e.c_drid = 1; e.drid = 5'd4; go();

        // 6: EXE not writing -> MEM ALU result
        @(negedge CLK); EXE_FWD_LD_REG = 1'b0;
        e = blank(6); e.c_a1 = 1; e.a1 = 64'hB; e.c_a2 = 1; e.a2 = 64'hB; go();

        // 7: MEM not writing either -> WB
        @(negedge CLK); MEM_FWD_LD_REG = 1'b0;
        e = blank(7); e.c_a1 = 1; e.a1 = 64'hC; e.c_a2 = 1; e.a2 = 64'hC; e.c_st = 1; e.st = 64'hC; go();

        // 8: every stage writes x0 with 0xFF, ADD x8,x0,x0 -> zeros, no interlock
        @(negedge CLK); clr(); DE_IR = 32'h00000433; RF_RS1 = 64'hFF; RF_RS2 = 64'hFF;
        EXE_FWD_V = 1'b1; EXE_FWD_LD_REG = 1'b1; EXE_FWD_IS_LOAD = 1'b1; EXE_FWD_DATA = 64'hFF;
        MEM_FWD_V = 1'b1; MEM_FWD_LD_REG = 1'b1; MEM_ALU_RESULT = 64'hFF; MEM_MEM_RESULT = 64'hFF;
        WB_FWD_V = 1'b1; WB_FWD_LD_REG = 1'b1; WB_FWD_DATA = 64'hFF;
        e = blank(8); e.c_a1 = 1; e.a1 = 64'h0; e.c_a2 = 1; e.a2 = 64'h0; e.c_stall = 1; e.stall = 1'b0;
        e.c_v = 1; e.v = 1'b1; e.c_drid = 1; e.drid = 5'd8; go();

        // 9: ADDI x9,x0,5 establishes a known EXE state
        @(negedge CLK); clr(); DE_IR = 32'h00500493; RF_RS1 = 64'h33;
        e = blank(9); e.c_v = 1; e.v = 1'b1; e.c_a1 = 1; e.a1 = 64'h0; e.c_a2 = 1; e.a2 = 64'h5;
        e.c_drid = 1; e.drid = 5'd9; e.c_imm = 1; e.imm = 64'h5; e.c_ir = 1; e.ir = 32'h00500493; go();

        // 10-12: MEM_STALL for three cycles with changing DE -> EXE latch frozen
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK); clr(); MEM_STALL = 1'b1;
            e = blank(10 + k);
            if (k == 0) begin DE_V = 1'b1; DE_IR = 32'h00728333; load_x5_in_exe(); end
            else if (k == 1) begin DE_V = 1'b1; DE_IR = 32'h0000006F; end
            else begin DE_V = 1'b0; DE_IR = 32'hFFF00093; end
            e.c_stall = 1; e.stall = (k == 0);
            e.c_br = 1; e.br = (k == 1);
            e.c_v = 1; e.v = 1'b1; e.c_a1 = 1; e.a1 = 64'h0; e.c_a2 = 1; e.a2 = 64'h5;
            e.c_drid = 1; e.drid = 5'd9; e.c_imm = 1; e.imm = 64'h5; e.c_ir = 1; e.ir = 32'h00500493;
            go();
        end

        // 13: FLUSH with a load-use hit -> no interlock, bubble
        @(negedge CLK); clr(); FLUSH = 1'b1; DE_V = 1'b1; DE_IR = 32'h00728333; load_x5_in_exe();
        e = blank(13); e.c_stall = 1; e.stall = 1'b0; e.c_v = 1; e.v = 1'b0; go();

        // 14: BEQ x1,x2,+8 -> rs2 to ALU_TWO, B immediate, DRID forced 0
        @(negedge CLK); clr(); DE_IR = 32'h00208463; RF_RS1 = 64'h11; RF_RS2 = 64'h22;
        e = blank(14); e.c_br = 1; e.br = 1'b1; e.c_v = 1; e.v = 1'b1; e.c_a1 = 1; e.a1 = 64'h11;
        e.c_a2 = 1; e.a2 = 64'h22; e.c_drid = 1; e.drid = 5'd0; e.c_imm = 1; e.imm = 64'h8; go();

        // 15: JAL x1,-4 at NPC 0x1004 -> ALU_ONE = PC, negative J immediate
        @(negedge CLK); DE_IR = 32'hFFDFF0EF; DE_NPC = 64'h1004;
        e = blank(15); e.c_br = 1; e.br = 1'b1; e.c_a1 = 1; e.a1 = 64'h1000;
        e.c_imm = 1; e.imm = 64'hFFFF_FFFF_FFFF_FFFC; e.c_a2 = 1; e.a2 = 64'hFFFF_FFFF_FFFF_FFFC;
        e.c_drid = 1; e.drid = 5'd1; e.c_npc = 1; e.npc = 64'h1004; go();

        // 16: LUI x10,0x12345 -> ALU_ONE zero even though rs1 field hits RF data
        @(negedge CLK); DE_IR = 32'h12345537; DE_NPC = 64'h0;
        e = blank(16); e.c_br = 1; e.br = 1'b0; e.c_a1 = 1; e.a1 = 64'h0; e.c_a2 = 1; e.a2 = 64'h1234_5000;
        e.c_imm = 1; e.imm = 64'h1234_5000; e.c_drid = 1; e.drid = 5'd10; go();

        // 17: SD x2,8(x1) -> S immediate, store data from rs2, DRID forced 0
        @(negedge CLK); DE_IR = 32'h0020B423; RF_RS1 = 64'h100; RF_RS2 = 64'h55;
        e = blank(17); e.c_a1 = 1; e.a1 = 64'h100; e.c_a2 = 1; e.a2 = 64'h8; e.c_st = 1; e.st = 64'h55;
        e.c_drid = 1; e.drid = 5'd0; e.c_imm = 1; e.imm = 64'h8; go();

        // 18: SLLI x1,x1,63 -> 6-bit shamt
        @(negedge CLK); DE_IR = 32'h03F09093;
        e = blank(18); e.c_imm = 1; e.imm = 64'd63; e.c_a2 = 1; e.a2 = 64'd63; e.c_ill = 1; e.ill = 1'b0; go();

        // 19: SRAI x1,x1,1 -> funct7 bits not part of the shamt
        @(negedge CLK); DE_IR = 32'h4010D093;
        e = blank(19); e.c_imm = 1; e.imm = 64'd1; go();

        // 20: unknown opcode -> illegal but still valid
        @(negedge CLK); DE_IR = 32'h0000007F;
        e = blank(20); e.c_v = 1; e.v = 1'b1; e.c_ill = 1; e.ill = 1'b1; go();

        // 21: ECALL
        @(negedge CLK); DE_IR = 32'h00000073;
        e = blank(21); e.c_ecall = 1; e.ecall = 1'b1; e.c_ill = 1; e.ill = 1'b0; go();

        // 22: SLLIW (OP-IMM-32) legal on RV64, illegal on RV32
        @(negedge CLK); DE_IR = 32'h0000101B;
        e = blank(22); e.c_ill = 1; e.ill = 1'b0; e.c_ecall = 1; e.ecall = 1'b0; e.c_imm = 1; e.imm = 64'h0;
        e.c_ill32 = 1; e.ill32 = 1'b1; go();

        // 23: SLLI x1,x1,32 legal on RV64, shamt[5] illegal on RV32
        @(negedge CLK); DE_IR = 32'h02009093;
        e = blank(23); e.c_ill = 1; e.ill = 1'b0; e.c_imm = 1; e.imm = 64'd32; e.c_ill32 = 1; e.ill32 = 1'b1; go();

        // 24: reset again before counting interlocks
        @(negedge CLK); reset = 1'b0;
        e = blank(24); e.c_v = 1; e.v = 1'b0; e.c_cnt = 1; e.cnt = 16'd0; go();

        // 25-28: four interlock cycles
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); reset = 1'b1; clr(); load_x5_in_exe(); DE_V = 1'b1; DE_IR = 32'h00728333;
            e = blank(25 + k); e.c_stall = 1; e.stall = 1'b1; e.c_v = 1; e.v = 1'b0;
            if (k == 3) begin e.c_cnt = 1; e.cnt = 16'(EXP_CNT); end
            go();
        end

        // 29: idle DE
        @(negedge CLK); clr(); DE_V = 1'b0;
        e = blank(29); e.c_v = 1; e.v = 1'b0; e.c_stall = 1; e.stall = 1'b0; e.c_cnt = 1; e.cnt = 16'(EXP_CNT); go();

        repeat (3) @(negedge CLK);
        chk(99, "queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage_fwd.md
Name: decode_stage_fwd

Overview:
- Parametrised decode stage between fetch (DE latch) and execute (EXE latch); XLEN-generic successor to the fixed 64-bit decoder.
- Generates all RV immediates (I/S/B/U/J); forwards rs1/rs2 from EXE, MEM and WB with fixed priority.
- Adds a load-use interlock (bubble insertion), flush, and illegal-instruction flagging.
- Register file is external: this block drives the read indices and consumes the read data.

Parameters:
- XLEN, 64, datapath width; only 32 and 64 are legal.
- CNT_W, 16, width of the optional stall counter.

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- DE_V  in  1  DE latch valid.
- DE_NPC  in  XLEN  PC+4 of the DE instruction.
- DE_IR  in  32  instruction.
- SR1_ID, SR2_ID  out  5 each  register file read indices, equal to DE_IR[19:15] and DE_IR[24:20].
- RF_RS1, RF_RS2  in  XLEN each  register file read data.
- EXE_FWD_V, EXE_FWD_LD_REG, EXE_FWD_IS_LOAD  in  1 each  EXE-stage producer info.
- EXE_FWD_DRID  in  5 / EXE_FWD_DATA  in  XLEN  EXE-stage destination and ALU result.
- MEM_FWD_V, MEM_FWD_LD_REG, MEM_FWD_IS_LOAD  in  1 each  MEM-stage producer info.
- MEM_FWD_DRID  in  5 / MEM_ALU_RESULT, MEM_MEM_RESULT  in  XLEN each.
- WB_FWD_V, WB_FWD_LD_REG  in  1 each / WB_FWD_DRID  in  5 / WB_FWD_DATA  in  XLEN.
- MEM_STALL  in  1  hold all EXE outputs.
- FLUSH  in  1  kill the instruction currently in DE.
- DE_STALL  out  1  load-use interlock; fetch must hold the DE latch.
- v_de_br_stall  out  1  DE_V and opcode is BRANCH, JAL or JALR.
- EXE_V, EXE_ECALL, EXE_ILLEGAL  out  1 each (registered).
- EXE_NPC, EXE_ALU_ONE, EXE_ALU_TWO, EXE_STORE_DATA, EXE_IMM  out  XLEN each (registered).
- EXE_IR  out  32 / EXE_DRID  out  5 (registered).
- STALL_CNT  out  CNT_W  optional-feature counter.

Behaviour:
- Reset (reset==0 at a CLK edge): every registered output is 0 (EXE_IR=0, EXE_V=0); STALL_CNT=0.
- Latency: one cycle, DE to EXE outputs. DE_STALL and v_de_br_stall are combinational.

Operand use:
- rs1 is used by OP, OP-IMM, OP-32, OP-IMM-32, LOAD, STORE, BRANCH and JALR.
- rs2 is used by OP, OP-32, STORE and BRANCH.

Forwarding, per source independently:
- A stage hits when its V && LD_REG && DRID==src && src!=0.
- Priority: EXE (only if !IS_LOAD) > MEM (MEM_MEM_RESULT if IS_LOAD, else MEM_ALU_RESULT) > WB > RF.
- src==0 always yields 0, regardless of RF data.

Load-use interlock:
- DE_STALL = DE_V && !FLUSH && EXE_FWD_V && EXE_FWD_IS_LOAD && EXE_FWD_DRID!=0 && (DRID matches a used rs1 or rs2).
- When DE_STALL is high and !MEM_STALL: EXE_V<=0 (bubble); the other EXE fields may update.

Immediates:
- I, S, B, U and J formats, each sign-extended to XLEN.
- Shift immediates are zero-extended: 6-bit shamt when XLEN=64, 5-bit when XLEN=32.
- OP-IMM-32 shamt is 5 bits.

ALU operands:
- ALU_ONE = DE_NPC-4 for AUIPC and JAL; 0 for LUI; forwarded rs1 otherwise.
- ALU_TWO = forwarded rs2 for OP, OP-32 and BRANCH; the immediate otherwise.
- EXE_STORE_DATA = forwarded rs2.
- EXE_IMM = the immediate.

Illegal instructions:
- EXE_ILLEGAL is set for an unknown opcode.
- It is also set for OP-32 or OP-IMM-32 when XLEN=32.
- It is also set for an RV32 shift with IR[25]=1 when XLEN=32.
- An illegal instruction still carries EXE_V.

ECALL: EXE_ECALL = (DE_IR==32'h00000073).

EXE_DRID: DE_IR[11:7]; forced to 0 for STORE and BRANCH.

Priority at each edge:
- reset > MEM_STALL (hold everything, counter frozen) > FLUSH (EXE_V<=0) > DE_STALL (EXE_V<=0) > normal (EXE_V<=DE_V).
- FLUSH together with a load-use hit: DE_STALL stays 0 (the instruction is dead).

Optional Feature:
- Macro DE_STALL_CNT_EN.
- Defined: STALL_CNT increments on each edge where DE_STALL && !MEM_STALL. It saturates at all-ones and clears on reset.
- Undefined: STALL_CNT is tied to 0 and no counter flops are built.

Decomposition:
- Shared package decode_pkg holds:
  - opcode localparams (OP, OP_IMM, OP_32, OP_IMM_32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM);
  - the ECALL encoding;
  - an immediate-format enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_SH).
- One sub-module, imm_gen: combinational, parametrised by XLEN; inputs IR, output immediate and format.

Test Plan:
- Reset, then DE_V=1 with IR=ADDI x1,x0,-1 (32'hFFF00093) -> next cycle EXE_ALU_TWO=all ones, EXE_DRID=1, EXE_V=1.
- EXE holds a load to x5 (IS_LOAD=1) and DE has ADD x6,x5,x7 -> DE_STALL=1 and EXE_V=0 next cycle. Then the load moves to MEM with MEM_MEM_RESULT=0x1234 -> EXE_ALU_ONE=0x1234.
- EXE, MEM and WB all write x3 with 0xA, 0xB, 0xC, and DE reads x3 -> 0xA. With EXE_FWD_LD_REG=0 -> 0xB.
- Any stage writes x0 with 0xFF and DE reads x0 -> the operand is 0.
- MEM_STALL held 3 cycles with a changing DE_IR -> all EXE outputs unchanged. FLUSH together with a load-use hit -> DE_STALL=0, EXE_V=0.
- XLEN=32: IR=32'h0000101B (OP-IMM-32) -> EXE_ILLEGAL=1. With DE_STALL_CNT_EN, 4 interlock cycles -> STALL_CNT=4.
